// File: rtl/channel_selector.sv
// rtl/channel_selector.sv - debounced channel browser with valid/ready select offer
//
// Purpose:
//   Debounces the raw next/prev/select push-buttons, keeps the browsed
//   channel (wrapping 0..NUM_CHANNELS-1) on locationSymbol, and on a select
//   press offers that channel on sel_valid/sel_symbol. Browsing is frozen
//   until the offer is accepted with sel_ready.
//
// Optional feature macro: CHANNEL_BLINK_EN
//   When defined, adds parameter BLINK_CYCLES and output blank, which blinks
//   (starting high) while an offer is pending and is low otherwise.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-high reset
//   btn_next       in   raw async button, next channel
//   btn_prev       in   raw async button, previous channel
//   btn_sel        in   raw async button, select current channel
//   sel_ready      in   consumer accepts the offered channel
//   locationSymbol out  browsed channel, 3 bits
//   sel_valid      out  a selected channel is on offer
//   sel_symbol     out  offered channel, stable while sel_valid=1
//   blank          out  display blank request (CHANNEL_BLINK_EN only)

module channel_selector #(
  parameter int NUM_CHANNELS    = 3,
  parameter int DEBOUNCE_CYCLES = 250000
`ifdef CHANNEL_BLINK_EN
  ,
  parameter int BLINK_CYCLES    = 12500000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       btn_sel,
  input  logic       sel_ready,
  output logic [2:0] locationSymbol,
  output logic       sel_valid,
  output logic [2:0] sel_symbol
`ifdef CHANNEL_BLINK_EN
  ,
  output logic       blank
`endif
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0] LAST_CH = 3'(NUM_CHANNELS - 1);

  localparam int NEXT = 0;
  localparam int PREV = 1;
  localparam int SEL  = 2;

`ifdef CHANNEL_BLINK_EN
  // Guard against a zero-width counter for a degenerate BLINK_CYCLES of 1.
  localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
  logic [BLINK_W-1:0] blinkCnt;
`endif

  typedef enum logic {
    SCAN = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state;

  logic [2:0]            rawBtn;
  logic [2:0]            sync1;
  logic [2:0]            sync2;
  logic [2:0]            debLevel;
  logic [2:0]            debLevelD;
  logic [2:0]            pressPulse;
  logic [2:0][CNT_W-1:0] debCnt;

  assign rawBtn = {btn_sel, btn_prev, btn_next};

  // Input path for all three buttons: 2-FF synchronizer, then a level is
  // accepted only after DEBOUNCE_CYCLES consecutive samples that disagree
  // with the current debounced level. Any agreeing sample restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1      <= '0;
      sync2      <= '0;
      debLevel   <= '0;
      debLevelD  <= '0;
      pressPulse <= '0;
      debCnt     <= '0;
    end else begin
      sync1      <= rawBtn;
      sync2      <= sync1;
      debLevelD  <= debLevel;
      // Rising edge of the debounced level only; releases are ignored.
      pressPulse <= debLevel & ~debLevelD;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] != debLevel[i]) begin
          if (debCnt[i] == DEB_LAST) begin
            debLevel[i] <= sync2[i];
            debCnt[i]   <= '0;
          end else begin
            debCnt[i] <= debCnt[i] + CNT_W'(1);
          end
        end else begin
          debCnt[i] <= '0;
        end
      end
    end
  end

  // Browse / offer state machine. All outputs are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= SCAN;
      locationSymbol <= '0;
      sel_valid      <= 1'b0;
      sel_symbol     <= '0;
`ifdef CHANNEL_BLINK_EN
      blank          <= 1'b0;
      blinkCnt       <= '0;
`endif
    end else begin
      case (state)
        SCAN: begin
`ifdef CHANNEL_BLINK_EN
          blank    <= 1'b0;
          blinkCnt <= '0;
`endif
          // Select wins over any browse pulse in the same cycle.
          if (pressPulse[SEL]) begin
            sel_symbol <= locationSymbol;
            sel_valid  <= 1'b1;
            state      <= HOLD;
`ifdef CHANNEL_BLINK_EN
            blank      <= 1'b1;
`endif
          end else if (pressPulse[NEXT] && !pressPulse[PREV]) begin
            locationSymbol <= (locationSymbol == LAST_CH) ? 3'd0 : locationSymbol + 3'd1;
          end else if (pressPulse[PREV] && !pressPulse[NEXT]) begin
            locationSymbol <= (locationSymbol == 3'd0) ? LAST_CH : locationSymbol - 3'd1;
          end
        end

        HOLD: begin
          // Button pulses are deliberately ignored while an offer is pending.
          if (sel_valid && sel_ready) begin
            sel_valid <= 1'b0;
            state     <= SCAN;
`ifdef CHANNEL_BLINK_EN
            blank     <= 1'b0;
            blinkCnt  <= '0;
`endif
          end else begin
`ifdef CHANNEL_BLINK_EN
            if (blinkCnt == BLINK_LAST) begin
              blank    <= ~blank;
              blinkCnt <= '0;
            end else begin
              blinkCnt <= blinkCnt + BLINK_W'(1);
            end
`endif
          end
        end

        default: begin
          state <= SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_channel_selector.sv
// tb/tb_channel_selector.sv - scoreboard bench for channel_selector

module tb_channel_selector;

  localparam int N   = 3;
  localparam int D   = 4;
  localparam int B   = 8;
  localparam int LAT = 4 + D;

  logic       clk;
  logic       reset;
  logic       btn_next;
  logic       btn_prev;
  logic       btn_sel;
  logic       sel_ready;
  logic [2:0] locationSymbol;
  logic       sel_valid;
  logic [2:0] sel_symbol;
`ifdef CHANNEL_BLINK_EN
  logic       blank;
`endif

  channel_selector #(
    .NUM_CHANNELS(N),
    .DEBOUNCE_CYCLES(D)
`ifdef CHANNEL_BLINK_EN
    ,
    .BLINK_CYCLES(B)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_next(btn_next),
    .btn_prev(btn_prev),
    .btn_sel(btn_sel),
    .sel_ready(sel_ready),
    .locationSymbol(locationSymbol),
    .sel_valid(sel_valid),
    .sel_symbol(sel_symbol)
`ifdef CHANNEL_BLINK_EN
    ,
    .blank(blank)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int val;
    int at;
  } ev_t;

  ev_t locQ[$];
  ev_t selQ[$];
  int  accQ[$];

  // Reference model state
  int curCh     = 0;
  bit inHold    = 1'b0;
  int holdEntry = 0;
  int holdExit  = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input int act);
    total++;
    bad++;
    $display("FAIL %s: got %0d with nothing expected (cycle %0d)", name, act, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output event
  logic [2:0] prevLoc   = '0;
  logic       prevValid = 1'b0;
  int         heldSym   = 0;
  ev_t        monEv;
  int         monAt;
  int         expBlank;

  always @(negedge clk) begin
    if (reset) begin
      prevLoc   = '0;
      prevValid = 1'b0;
    end else begin
      check("loc_range", int'(locationSymbol < 3'(N)), 1);
      if (locationSymbol != prevLoc) begin
        if (locQ.size() == 0) unexpected("loc_change", int'(locationSymbol));
        else begin
          monEv = locQ.pop_front();
          check("loc_value", int'(locationSymbol), monEv.val);
          check("loc_cycle", cyc, monEv.at);
        end
        prevLoc = locationSymbol;
      end
      if (sel_valid && !prevValid) begin
        if (selQ.size() == 0) unexpected("sel_rise", int'(sel_symbol));
        else begin
          monEv = selQ.pop_front();
          heldSym = monEv.val;
          check("sel_symbol", int'(sel_symbol), monEv.val);
          check("sel_cycle", cyc, monEv.at);
        end
      end else if (sel_valid) begin
        check("sel_stable", int'(sel_symbol), heldSym);
      end
      if (!sel_valid && prevValid) begin
        if (accQ.size() == 0) unexpected("sel_fall", cyc);
        else begin
          monAt = accQ.pop_front();
          check("accept_cycle", cyc, monAt);
        end
      end
      prevValid = sel_valid;
`ifdef CHANNEL_BLINK_EN
      if (cyc >= holdEntry && cyc < holdExit) expBlank = (((cyc - holdEntry) / B) % 2 == 0) ? 1 : 0;
      else expBlank = 0;
      check("blank", int'(blank), expBlank);
`endif
    end
  end

  task automatic drive(input int which, input logic v);
    case (which)
      0: btn_next = v;
      1: btn_prev = v;
      default: btn_sel = v;
    endcase
  endtask

  // which: 0 next, 1 prev, 2 select. hold = raw high cycles.
  task automatic press(input int which, input int hold);
    int  c;
    int  gap;
    ev_t e;
    @(negedge clk);
    c = cyc;
    if (hold >= D && !inHold) begin
      if (which == 2) begin
        e.val = curCh;
        e.at  = c + LAT;
        selQ.push_back(e);
        inHold    = 1'b1;
        holdEntry = c + LAT;
        holdExit  = 1 << 30;
      end else begin
        curCh = (which == 0) ? (curCh + 1) % N : (curCh + N - 1) % N;
        e.val = curCh;
        e.at  = c + LAT;
        locQ.push_back(e);
      end
    end
    drive(which, 1'b1);
    repeat (hold) @(negedge clk);
    drive(which, 1'b0);
    gap = D + 4 + int'($urandom_range(0, 5));
    repeat (gap) @(negedge clk);
  endtask

  task automatic press_both(input int hold);
    @(negedge clk);
    btn_next = 1'b1;
    btn_prev = 1'b1;
    repeat (hold) @(negedge clk);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    repeat (D + 6) @(negedge clk);
  endtask

  task automatic accept();
    @(negedge clk);
    sel_ready = 1'b1;
    if (inHold) begin
      accQ.push_back(cyc + 1);
      holdExit = cyc + 1;
      inHold   = 1'b0;
    end
    @(negedge clk);
    sel_ready = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic settle_check(input string name);
    repeat (2) @(negedge clk);
    check({name, "_loc"}, int'(locationSymbol), curCh);
    check({name, "_valid"}, int'(sel_valid), int'(inHold));
    check({name, "_pending"}, locQ.size() + selQ.size() + accQ.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    reset     = 1'b1;
    btn_next  = 1'b0;
    btn_prev  = 1'b0;
    btn_sel   = 1'b0;
    sel_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_loc", int'(locationSymbol), 0);
    check("reset_valid", int'(sel_valid), 0);
    check("reset_symbol", int'(sel_symbol), 0);
`ifdef CHANNEL_BLINK_EN
    check("reset_blank", int'(blank), 0);
`endif
    #2 reset = 1'b0;

    // Held button: one step at exact latency, no auto-repeat
    press(0, 50);
    settle_check("held_next");

    // Clean presses incl. wrap in both directions
    press(0, D + 1);
    press(0, D + 2);
    settle_check("wrap_next");
    press(1, D);
    settle_check("wrap_prev");
    press(0, D + 3);

    // Short glitch and aligned next+prev: no change
    press(0, 3);
    settle_check("glitch");
    press_both(D + 2);
    settle_check("both");

    // Reach channel 2, select, try browsing while frozen, then accept
    press(1, D + 1);
    settle_check("to_two");
    press(2, D + 2);
    press(0, D + 1);
    press(0, D + 1);
    press(1, D + 1);
    press(2, D + 1);
    settle_check("frozen");
    repeat (10) @(negedge clk);
    accept();
    press(0, D + 1);
    settle_check("after_accept");

    // sel_ready without a pending offer
    @(negedge clk);
    sel_ready = 1'b1;
    repeat (5) @(negedge clk);
    sel_ready = 1'b0;
    settle_check("ready_idle");

    // Randomized mix
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 3) press(0, D + int'($urandom_range(0, 5)));
      else if (r <= 6) press(1, D + int'($urandom_range(0, 5)));
      else if (r == 7) press(int'($urandom_range(0, 2)), int'($urandom_range(1, D - 1)));
      else if (r == 8) press(2, D + int'($urandom_range(0, 5)));
      else begin
        repeat (int'($urandom_range(0, 20))) @(negedge clk);
        accept();
      end
    end
    if (inHold) accept();
    settle_check("random");

    // Async reset while an offer is pending
    for (int k = 0; k < 2; k++) if (curCh == 0) press(0, D + 1);
    press(2, D + 1);
    settle_check("pre_reset_hold");
    @(negedge clk);
    #2 reset = 1'b1;
    curCh    = 0;
    inHold   = 1'b0;
    holdExit = cyc;
    #1;
    check("async_rst_valid", int'(sel_valid), 0);
    check("async_rst_loc", int'(locationSymbol), 0);
`ifdef CHANNEL_BLINK_EN
    check("async_rst_blank", int'(blank), 0);
`endif
    @(negedge clk);
    #2 reset = 1'b0;
    press(0, D + 1);
    settle_check("post_reset");

    repeat (20) @(negedge clk);
    check("locQ_drained", locQ.size(), 0);
    check("selQ_drained", selQ.size(), 0);
    check("accQ_drained", accQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
